// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus arbiter: requester IDs and access-size encodings.
package sram_bus_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_order_fifo.sv
// 1-bit-wide synchronous FIFO that remembers which requester issued each outstanding bus transaction.
module sram_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic empty,
    output logic full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // NOTE: storage is not reset; an entry is only read after count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one SRAM-like bus and routes
// in-order responses back to the requester that issued each transaction.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    logic lock_vld_q;
    src_e lock_src_q;
    logic bus_err_q;

    src_e grant_src;
    logic grant_req;
    logic addr_accept;
    logic fifo_head, fifo_empty, fifo_full;
    src_e head_src;

    // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
    always_comb begin
        grant_src = SRC_INST;
        if (lock_vld_q)    grant_src = lock_src_q;
        else if (data_req) grant_src = SRC_DATA;
    end

    assign grant_req   = (grant_src == SRC_DATA) ? data_req : inst_req;
    assign bus_req     = grant_req && !fifo_full;
    assign addr_accept = bus_req && bus_addr_ok;

    always_comb begin
        bus_wr    = inst_wr;
        bus_size  = inst_size;
        bus_wstrb = inst_wstrb;
        bus_addr  = inst_addr;
        bus_wdata = inst_wdata;
        if (grant_src == SRC_DATA) begin
            bus_wr    = data_wr;
            bus_size  = data_size;
            bus_wstrb = data_wstrb;
            bus_addr  = data_addr;
            bus_wdata = data_wdata;
        end
    end

    assign inst_addr_ok = addr_accept && (grant_src == SRC_INST);
    assign data_addr_ok = addr_accept && (grant_src == SRC_DATA);

    // A presented but unaccepted request keeps the bus until accepted, even if data arrives.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_src_q <= SRC_INST;
            bus_err_q  <= 1'b0;
        end else begin
            if (bus_req && !bus_addr_ok) begin
                lock_vld_q <= 1'b1;
                lock_src_q <= grant_src;
            end else if (addr_accept) begin
                lock_vld_q <= 1'b0;
            end
            if (bus_data_ok && fifo_empty) bus_err_q <= 1'b1;
        end
    end

    sram_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (addr_accept),
        .pop   (bus_data_ok),
        .din   (grant_src),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign head_src     = src_e'(fifo_head);
    assign inst_data_ok = bus_data_ok && !fifo_empty && (head_src == SRC_INST);
    assign data_data_ok = bus_data_ok && !fifo_empty && (head_src == SRC_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter: priority, hold, full, push+pop, error cases.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Pop one response and check it lands on the expected requester.
    task automatic expect_resp(input string name, input logic to_data, input logic [31:0] rd);
        bus_data_ok = 1'b1; bus_rdata = rd;
        #1;
        checks++;
        if (inst_data_ok !== !to_data || data_data_ok !== to_data) begin
            errors++;
            $display("FAIL %s: inst_data_ok=%0b data_data_ok=%0b, expected %0b/%0b",
                     name, inst_data_ok, data_data_ok, !to_data, to_data);
        end
        checks++;
        if ((to_data ? data_rdata : inst_rdata) !== rd) begin
            errors++;
            $display("FAIL %s_rdata: got %h expected %h", name, to_data ? data_rdata : inst_rdata, rd);
        end
        tick();
        bus_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_err});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h1C00_0000) begin
            errors++;
            $display("FAIL fetch_bus: bus_req=%0b bus_addr=%h expected 1/1c000000", bus_req, bus_addr);
        end
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_addr_ok: inst=%0b data=%0b expected 1/0", inst_addr_ok, data_addr_ok);
        end
        tick();
        idle();
        tick();
        expect_resp("fetch_resp", 1'b0, 32'h0280_0C0C);
    endtask

    task automatic test_priority();
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        data_req = 1'b1; data_addr = 32'h8000_1000; data_wr = 1'b1;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (bus_addr !== 32'h8000_1000 || bus_wr !== 1'b1 || bus_wstrb !== 4'hF || bus_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL prio_data_fields: addr=%h wr=%0b wstrb=%h wdata=%h expected 80001000/1/f/deadbeef",
                     bus_addr, bus_wr, bus_wstrb, bus_wdata);
        end
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL prio_first: data_addr_ok=%0b inst_addr_ok=%0b expected 1/0", data_addr_ok, inst_addr_ok);
        end
        tick();
        data_req = 1'b0;
        #1;
        checks++;
        if (bus_addr !== 32'h1C00_0004 || inst_addr_ok !== 1'b1 || bus_wr !== 1'b0) begin
            errors++;
            $display("FAIL prio_second: addr=%h inst_addr_ok=%0b wr=%0b expected 1c000004/1/0",
                     bus_addr, inst_addr_ok, bus_wr);
        end
        tick();
        idle();
        expect_resp("prio_resp0", 1'b1, 32'h0000_0000);
        expect_resp("prio_resp1", 1'b0, 32'h1111_2222);
    endtask

    task automatic test_hold();
        inst_req = 1'b1; inst_addr = 32'h1C00_0100; bus_addr_ok = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h1C00_0100 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL hold_c1: req=%0b addr=%h iok=%0b expected 1/1c000100/0", bus_req, bus_addr, inst_addr_ok);
        end
        tick();
        data_req = 1'b1; data_addr = 32'h8000_2000;
        for (int c = 2; c <= 3; c++) begin
            #1;
            checks++;
            if (bus_addr !== 32'h1C00_0100 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
                errors++;
                $display("FAIL hold_c%0d: addr=%h iok=%0b dok=%0b expected 1c000100/0/0",
                         c, bus_addr, inst_addr_ok, data_addr_ok);
            end
            tick();
        end
        bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (bus_addr !== 32'h1C00_0100 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept: addr=%h iok=%0b dok=%0b expected 1c000100/1/0",
                     bus_addr, inst_addr_ok, data_addr_ok);
        end
        tick();
        inst_req = 1'b0;
        #1;
        checks++;
        if (bus_addr !== 32'h8000_2000 || data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL hold_data_after: addr=%h dok=%0b expected 80002000/1", bus_addr, data_addr_ok);
        end
        tick();
        idle();
        expect_resp("hold_resp0", 1'b0, 32'hAAAA_0001);
        expect_resp("hold_resp1", 1'b1, 32'hAAAA_0002);
    endtask

    task automatic test_full();
        bus_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_req = (i % 2 == 0);
            data_req = (i % 2 == 1);
            #1;
            checks++;
            if ((i % 2 == 0 ? inst_addr_ok : data_addr_ok) !== 1'b1) begin
                errors++;
                $display("FAIL full_issue%0d: addr_ok=0 expected 1", i);
            end
            tick();
        end
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0200;
        #1;
        checks++;
        if (bus_req !== 1'b0 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL full_blocked: bus_req=%0b iok=%0b expected 0/0", bus_req, inst_addr_ok);
        end
        bus_data_ok = 1'b1; bus_rdata = 32'h0000_0F00;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: iok=%0b dok=%0b bus_req=%0b expected 1/0/0", inst_data_ok, data_data_ok, bus_req);
        end
        tick();
        bus_data_ok = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b1 || inst_addr_ok !== 1'b1 || bus_addr !== 32'h1C00_0200) begin
            errors++;
            $display("FAIL full_fifth: bus_req=%0b iok=%0b addr=%h expected 1/1/1c000200", bus_req, inst_addr_ok, bus_addr);
        end
        tick();
        idle();
        expect_resp("full_drain0", 1'b1, 32'h0000_0F01);
        expect_resp("full_drain1", 1'b0, 32'h0000_0F02);
        expect_resp("full_drain2", 1'b1, 32'h0000_0F03);
        expect_resp("full_drain3", 1'b0, 32'h0000_0F04);
    endtask

    task automatic test_back_to_back();
        bus_addr_ok = 1'b1;
        inst_req = 1'b1; tick();
        inst_req = 1'b0; data_req = 1'b1; tick();
        data_req = 1'b0; inst_req = 1'b1;
        bus_data_ok = 1'b1; bus_rdata = 32'h0000_B2B0;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL b2b_push_pop: iaok=%0b idok=%0b ddok=%0b expected 1/1/0",
                     inst_addr_ok, inst_data_ok, data_data_ok);
        end
        tick();
        bus_data_ok = 1'b0; inst_req = 1'b0; data_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (data_addr_ok !== 1'b1) begin
                errors++;
                $display("FAIL b2b_refill%0d: data_addr_ok=0 expected 1", i);
            end
            tick();
        end
        data_req = 1'b0; inst_req = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count_full: bus_req=%0b expected 0", bus_req);
        end
        idle();
        expect_resp("b2b_drain0", 1'b1, 32'h0000_B2B1);
        expect_resp("b2b_drain1", 1'b0, 32'h0000_B2B2);
        expect_resp("b2b_drain2", 1'b1, 32'h0000_B2B3);
        expect_resp("b2b_drain3", 1'b1, 32'h0000_B2B4);
    endtask

    task automatic test_empty_err();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_before: bus_err=%0b expected 0", bus_err);
        end
        bus_data_ok = 1'b1;
        #1;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL err_no_route: iok=%0b dok=%0b expected 0/0", inst_data_ok, data_data_ok);
        end
        tick();
        bus_data_ok = 1'b0;
        tick();
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: bus_err=%0b expected 1", bus_err);
        end
        do_reset();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: bus_err=%0b expected 0", bus_err);
        end
    endtask

    task automatic test_reset_mid();
        bus_addr_ok = 1'b1;
        inst_req = 1'b1; tick();
        inst_req = 1'b0; data_req = 1'b1; bus_addr_ok = 1'b0; tick();
        do_reset();
        inst_req = 1'b1; bus_addr_ok = 1'b0; data_req = 1'b1;
        #1;
        checks++;
        if (bus_addr_ok !== 1'b0 || bus_addr !== data_addr) begin
            errors++;
            $display("FAIL rstmid_lock_cleared: bus_addr=%h expected %h", bus_addr, data_addr);
        end
        idle();
        bus_data_ok = 1'b1;
        #1;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_late_resp: iok=%0b dok=%0b expected 0/0", inst_data_ok, data_data_ok);
        end
        tick();
        bus_data_ok = 1'b0;
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_err: bus_err=%0b expected 1", bus_err);
        end
        do_reset();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        test_reset();
        test_single_fetch();
        test_priority();
        test_hold();
        test_full();
        test_back_to_back();
        test_empty_err();
        inst_addr = 32'h1C00_0300; data_addr = 32'h8000_3000;
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Arbitrates the instruction-fetch port and the data (load/store) port of the CPU onto one shared SRAM-like bus (req/addr_ok/data_ok). Lives between the pipeline stages (IF issues `inst_*`, EX issues `data_*`; IF and MEM consume responses) and the bus bridge. Grants address phases with data priority and a hold rule. Tracks outstanding transactions in issue order, so each `bus_data_ok` returns to the requester that issued it.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_OUTSTANDING`, 4, order-FIFO depth (power of two, ≥2)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `inst_req`  in  1  fetch request valid, held until `inst_addr_ok`
- `inst_wr`, `inst_size`, `inst_wstrb`, `inst_addr`, `inst_wdata`  in  1/2/4/ADDR_W/DATA_W  fetch request fields
- `inst_addr_ok`  out  1  fetch address accepted
- `inst_data_ok`  out  1  fetch response valid
- `inst_rdata`  out  DATA_W  fetch read data
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`  in  1/1/2/4/ADDR_W/DATA_W  load/store request
- `data_addr_ok`  out  1  load/store address accepted
- `data_data_ok`  out  1  load/store response (load data or store done)
- `data_rdata`  out  DATA_W  load data
- `bus_req`, `bus_wr`, `bus_size`, `bus_wstrb`, `bus_addr`, `bus_wdata`  out  1/1/2/4/ADDR_W/DATA_W  shared bus request
- `bus_addr_ok`  in  1  bus accepted address
- `bus_data_ok`  in  1  bus response valid, strictly in issue order
- `bus_rdata`  in  DATA_W  bus read data
- `bus_err`  out  1  sticky: `bus_data_ok` seen with no outstanding transaction

## Operation
- Grant selection:
  - If `lock_vld`, grant `lock_src`.
  - Otherwise grant data if `data_req`, else inst if `inst_req`.
- Hold rule: if `bus_req && !bus_addr_ok`, register `lock_src` = granted source and set `lock_vld`. Clear `lock_vld` on the cycle `bus_req && bus_addr_ok`. A lower-priority request is never preempted once presented.
- `bus_req` = granted request && !fifo_full. Bus request fields are a mux of the granted source.
- `inst_addr_ok` = `bus_addr_ok && bus_req && grant==INST`. `data_addr_ok` is analogous.
- Order FIFO holds a 1-bit source ID.
  - Push the granted source on `bus_req && bus_addr_ok`.
  - Pop on `bus_data_ok`.
  - Count width is clog2(MAX_OUTSTANDING)+1; pointers wrap modulo depth.
- Response routing:
  - `inst_data_ok` = `bus_data_ok && !empty && head==INST`; `data_data_ok` is analogous.
  - `inst_rdata` = `data_rdata` = `bus_rdata`, unqualified.
- Boundaries:
  - Full: `bus_req`=0 and no `addr_ok`, even if `bus_addr_ok` is high.
  - Simultaneous push+pop when not full: count unchanged, both pointers advance.
  - Push+pop when full is impossible, because push is gated.
  - `bus_data_ok` when empty: no pop, no requester `data_ok`, `bus_err`←1 until reset.
  - Both requests with no lock: data wins; inst waits, its req held.
- Reset mid-transaction: FIFO emptied, `lock_vld`=0, `bus_err`=0. Responses returning later are treated as the empty case. The bus is reset together with this block.

## Timing
- Address path is combinational, 0 cycles: req→`bus_req`, `bus_addr_ok`→requester `addr_ok` in the same cycle.
- Response path is combinational, 0 cycles: `bus_data_ok`→requester `data_ok`.
- Registered state: FIFO storage, pointers, count, `lock_vld`, `lock_src`, `bus_err`.
- Reset values:
  - `bus_req`=0, all `addr_ok`/`data_ok`=0, `bus_err`=0.
  - Muxed data/address outputs follow inputs; their value is don't-care while `bus_req`=0.
- Throughput: one address acceptance per cycle up to `MAX_OUTSTANDING` in flight.
- A newly pushed entry can be popped no earlier than the next cycle, because the head reads registered storage.

## Structure
- Shared package `sram_bus_pkg`:
  - source ID constants `SRC_INST`=0, `SRC_DATA`=1
  - size encodings: 0 byte, 1 half, 2 word
- Sub-module `sram_order_fifo`, a parameterised 1-bit-wide synchronous FIFO. Its ports are push, pop, din, head, empty, full.
- The top level holds grant/lock logic and the muxes.

## Test plan
- Idle, `inst_req`=1 at 0x1C000000, `bus_addr_ok`=1 → same-cycle `bus_addr`=0x1C000000, `inst_addr_ok`=1. Later `bus_data_ok` with rdata 0x02800C0C → `inst_data_ok`=1, `inst_rdata`=0x02800C0C, `data_data_ok`=0.
- `inst_req` and `data_req` together, `bus_addr_ok`=1 → data granted first; inst granted next cycle. Two `bus_data_ok` → `data_data_ok` then `inst_data_ok`.
- `inst_req` with `bus_addr_ok`=0 for 3 cycles, `data_req` rising in cycle 2 → bus keeps the inst address until accepted; data is granted after.
- Issue 4 transactions with no `data_ok` (depth 4) → 5th request sees `bus_req`=0. One `bus_data_ok` → 5th accepted the next cycle.
- Push and pop in the same cycle at count 2 → count stays 2, routing order preserved.
- `bus_data_ok` with an empty FIFO → no requester `data_ok`, `bus_err`=1 until `reset`.
